// File: rtl/spectrum_gfx_pkg.sv
// Shared graphics types for the spectrum renderer: RGB332 pixel, bar palette, peak colour.
package spectrum_gfx_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Rainbow sweep across the first 14 bars, then two muted tones.
  localparam rgb332_t PALETTE [16] = '{
    8'hE0, 8'hEC, 8'hF4, 8'hFC, 8'h9C, 8'h1C, 8'h1D, 8'h1F,
    8'h13, 8'h03, 8'h63, 8'hA3, 8'hE3, 8'hE1, 8'h92, 8'h49
  };

  localparam rgb332_t PEAK_COLOUR = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb332_t BLACK       = '{r: 3'd0, g: 3'd0, b: 2'd0};

endpackage

// File: rtl/spectrum_peak_tracker.sv
// Per-bar peak marker: holds the highest recent height, then decays toward the live height.
module spectrum_peak_tracker #(
  parameter int H_W         = 9,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           update,
  input  logic [H_W-1:0] h,
  output logic [H_W-1:0] p
);

  localparam int T_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [H_W-1:0] p_reg;
  logic [T_W-1:0] t_reg;
  logic [H_W-1:0] decayed;

  assign decayed = (int'(p_reg) > DECAY) ? p_reg - H_W'(DECAY) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg <= '0;
      t_reg <= '0;
    end else if (update) begin
      if (h >= p_reg) begin
        p_reg <= h;
        t_reg <= T_W'(HOLD_FRAMES);
      end else if (t_reg != '0) begin
        t_reg <= t_reg - T_W'(1);
      end else begin
        p_reg <= (decayed > h) ? decayed : h;
      end
    end
  end

  assign p = p_reg;

endmodule

// File: rtl/spectrum_bar_renderer.sv
// Bar-graph spectrum renderer with a 2-cycle pixel pipeline.
// Optional peak markers are enabled by defining SPECTRUM_PEAK_HOLD_EN.
module spectrum_bar_renderer
  import spectrum_gfx_pkg::*;
#(
  parameter int N_BARS      = 16,
  parameter int BAR_W_LOG2  = 5,
  parameter int GAP         = 2,
  parameter int MAG_W       = 36,
  parameter int SCREEN_H    = 480,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             active,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic [MAG_W-1:0] magnitudes [N_BARS],
  output logic [2:0]       red_out,
  output logic [2:0]       green_out,
  output logic [1:0]       blue_out
);

  localparam int H_W      = $clog2(SCREEN_H + 1);
  localparam int B_W      = 10 - BAR_W_LOG2;
  localparam int LIT_COLS = (1 << BAR_W_LOG2) - GAP;
  localparam logic [MAG_W/2-1:0] SAT_MAG = (MAG_W/2)'(SCREEN_H);

  if (N_BARS < 1 || N_BARS > 32 || GAP < 0 || LIT_COLS < 1 || (MAG_W % 2) != 0 ||
      HOLD_FRAMES < 0 || DECAY < 0) begin : g_bad_params
    $error("spectrum_bar_renderer: illegal parameter set");
  end

  logic [H_W-1:0] h_shadow [N_BARS];
`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [H_W-1:0] p_shadow [N_BARS];
`endif

  for (genvar gi = 0; gi < N_BARS; gi++) begin : g_bar
    logic [MAG_W/2-1:0] upper;
    logic [H_W-1:0]     h_next;
    logic [H_W-1:0]     h_reg;
    logic               unused_low;

    assign upper      = magnitudes[gi][MAG_W-1:MAG_W/2];
    assign unused_low = ^magnitudes[gi][MAG_W/2-1:0];
    assign h_next     = (upper > SAT_MAG) ? H_W'(SCREEN_H) : H_W'(upper);

    always_ff @(posedge clk) begin
      if (rst) h_reg <= '0;
      else if (frame_start) h_reg <= h_next;
    end
    assign h_shadow[gi] = h_reg;

`ifdef SPECTRUM_PEAK_HOLD_EN
    spectrum_peak_tracker #(
      .H_W(H_W), .HOLD_FRAMES(HOLD_FRAMES), .DECAY(DECAY)
    ) u_peak (
      .clk(clk), .rst(rst), .update(frame_start), .h(h_next), .p(p_shadow[gi])
    );
`endif
  end

  // Stage 1 captures the selected bar's shadow values alongside the pixel, so a
  // frame_start in the same cycle only affects pixels presented afterwards.
  logic [B_W-1:0]        b_in;
  logic [BAR_W_LOG2-1:0] c_in;
  logic                  in_bar;
  logic [H_W-1:0]        h_sel;

  assign b_in   = x[9:BAR_W_LOG2];
  assign c_in   = x[BAR_W_LOG2-1:0];
  assign in_bar = active && (int'(b_in) < N_BARS) && (int'(c_in) < LIT_COLS);

  always_comb begin
    h_sel = '0;
    for (int i = 0; i < N_BARS; i++)
      if (int'(b_in) == i) h_sel = h_shadow[i];
  end

  logic           valid_reg;
  logic [9:0]     y_reg;
  logic [H_W-1:0] h_sel_reg;
  logic [3:0]     pal_idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      y_reg       <= '0;
      h_sel_reg   <= '0;
      pal_idx_reg <= '0;
    end else begin
      valid_reg   <= in_bar;
      y_reg       <= y;
      h_sel_reg   <= h_sel;
      pal_idx_reg <= 4'(b_in);
    end
  end

  logic [10:0] y_ext;
  logic [10:0] bar_top;
  logic        bar_on;
  rgb332_t     colour;

  assign y_ext   = {1'b0, y_reg};
  assign bar_top = 11'(SCREEN_H) - 11'(h_sel_reg);
  assign bar_on  = valid_reg && (y_ext >= bar_top);

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [H_W-1:0] p_sel;
  logic [H_W-1:0] p_sel_reg;
  logic [10:0]    peak_top;
  logic           peak_on;

  always_comb begin
    p_sel = '0;
    for (int i = 0; i < N_BARS; i++)
      if (int'(b_in) == i) p_sel = p_shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) p_sel_reg <= '0;
    else p_sel_reg <= p_sel;
  end

  // Marker is two rows tall, starting at the peak's top row.
  assign peak_top = 11'(SCREEN_H) - 11'(p_sel_reg);
  assign peak_on  = valid_reg && (p_sel_reg != '0) &&
                    ((y_ext == peak_top) || (y_ext == peak_top + 11'd1));
  assign colour   = peak_on ? PEAK_COLOUR : (bar_on ? PALETTE[pal_idx_reg] : BLACK);
`else
  assign colour   = bar_on ? PALETTE[pal_idx_reg] : BLACK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      red_out   <= colour.r;
      green_out <= colour.g;
      blue_out  <= colour.b;
    end
  end

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Self-checking bench for spectrum_bar_renderer: table-driven pixels through a 2-deep scoreboard.
module tb_spectrum_bar_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        active = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [35:0] mags [16];
    logic [2:0]  red_out, green_out;
    logic [1:0]  blue_out;
    logic        done = 1'b0;

    always #5 clk = ~clk;

    spectrum_bar_renderer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .active(active),
        .x(x), .y(y), .magnitudes(mags),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
    );

    localparam logic [7:0] PAL [16] = '{
        8'hE0, 8'hEC, 8'hF4, 8'hFC, 8'h9C, 8'h1C, 8'h1D, 8'h1F,
        8'h13, 8'h03, 8'h63, 8'hA3, 8'hE3, 8'hE1, 8'h92, 8'h49
    };
    localparam logic [7:0] WHITE = 8'hFF;

    typedef struct {
        logic       chk;
        logic [7:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        int         px;
        int         py;
        logic       a;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  sb_q [$];
    vec_t tbl [$];
    int   checks = 0;
    int   errors = 0;

    // One drive per clock; the matching output is compared two edges later.
    task automatic drive(input logic r, input logic fs, input logic a, input int px, input int py,
                         input logic chk, input logic [7:0] e, input string nm);
        sb_t s;
        @(posedge clk);
        #1;
        rst = r; frame_start = fs; active = a;
        x = 10'(px); y = 10'(py);
        s.chk = chk; s.exp = e; s.name = nm;
        sb_q.push_back(s);
    endtask

    task automatic set_mag(input int i, input int v);
        mags[i] = {18'(v), 18'h2A5A5};
    endtask

    always @(posedge clk) begin
        sb_t s;
        logic [7:0] act;
        #2;
        if (sb_q.size() >= 3) begin
            s = sb_q.pop_front();
            if (s.chk) begin
                act = {red_out, green_out, blue_out};
                checks++;
                if (act !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h", s.name, act, s.exp);
                end else begin
                    $display("check %s: got %02h ok", s.name, act);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL watchdog: stimulus did not complete before timeout");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    int pm = 0;
    int tm = 0;

    task automatic peak_model(input int h);
        if (h >= pm) begin
            pm = h; tm = 30;
        end else if (tm > 0) begin
            tm--;
        end else begin
            pm = (pm - 4 > h) ? pm - 4 : h;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mags[i] = {18'd900, 18'h0};

        // Reset held 3 cycles, frame_start also high: outputs stay 0 and heights stay 0.
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 96 + i, 479, 1, 8'h00, "reset_sweep");
        checks++;
        if ({red_out, green_out, blue_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %02h expected 00", {red_out, green_out, blue_out});
        end else begin
            $display("check reset_state: got %02h ok", {red_out, green_out, blue_out});
        end
        drive(0, 0, 1, 96, 0, 1, 8'h00, "post_reset_b3");
        drive(0, 0, 1, 0, 479, 1, 8'h00, "post_reset_b0");

`ifdef SPECTRUM_PEAK_HOLD_EN
        for (int i = 0; i < 16; i++) set_mag(i, 0);
        set_mag(0, 200);
        drive(0, 1, 0, 0, 0, 0, 8'h00, "fs");
        peak_model(200);
        set_mag(0, 0);
        drive(0, 0, 1, 0, 480 - pm, 1, WHITE, "peak_first");
        drive(0, 0, 1, 0, 479 - pm, 1, 8'h00, "peak_above_first");
        for (int f = 0; f < 90; f++) begin
            drive(0, 1, 0, 0, 0, 0, 8'h00, "fs");
            peak_model(0);
            if (pm > 0) begin
                drive(0, 0, 1, 0, 480 - pm, 1, WHITE, "peak_row");
                drive(0, 0, 1, 0, 481 - pm, 1, WHITE, "peak_row2");
                drive(0, 0, 1, 0, 479 - pm, 1, 8'h00, "peak_above");
            end else begin
                drive(0, 0, 1, 0, 479, 1, 8'h00, "peak_gone");
            end
        end
`else
        for (int i = 0; i < 16; i++) set_mag(i, 0);
        set_mag(0, 100);
        set_mag(3, 1000);
        set_mag(5, 480);
        set_mag(7, 1);
        set_mag(15, 240);
        drive(0, 1, 0, 0, 0, 0, 8'h00, "fs");

        tbl.push_back('{0,    379, 1'b1, 8'h00,   "b0_above"});
        tbl.push_back('{0,    380, 1'b1, PAL[0],  "b0_top"});
        tbl.push_back('{0,    479, 1'b1, PAL[0],  "b0_bottom"});
        tbl.push_back('{29,   380, 1'b1, PAL[0],  "b0_lastcol"});
        tbl.push_back('{30,   400, 1'b1, 8'h00,   "b0_gap30"});
        tbl.push_back('{31,   479, 1'b1, 8'h00,   "b0_gap31"});
        tbl.push_back('{32,   479, 1'b1, 8'h00,   "b1_h0"});
        tbl.push_back('{96,   0,   1'b1, PAL[3],  "b3_sat_row0"});
        tbl.push_back('{125,  0,   1'b1, PAL[3],  "b3_col125"});
        tbl.push_back('{110,  240, 1'b1, PAL[3],  "b3_mid"});
        tbl.push_back('{126,  0,   1'b1, 8'h00,   "b3_gap126"});
        tbl.push_back('{127,  479, 1'b1, 8'h00,   "b3_gap127"});
        tbl.push_back('{160,  0,   1'b1, PAL[5],  "b5_full"});
        tbl.push_back('{224,  479, 1'b1, PAL[7],  "b7_h1"});
        tbl.push_back('{224,  478, 1'b1, 8'h00,   "b7_above"});
        tbl.push_back('{480,  240, 1'b1, PAL[15], "b15_top"});
        tbl.push_back('{480,  239, 1'b1, 8'h00,   "b15_above"});
        tbl.push_back('{512,  479, 1'b1, 8'h00,   "x512_bg"});
        tbl.push_back('{1023, 479, 1'b1, 8'h00,   "x1023_bg"});
        tbl.push_back('{96,   100, 1'b0, 8'h00,   "inactive"});
        foreach (tbl[i]) drive(0, 0, tbl[i].a, tbl[i].px, tbl[i].py, 1, tbl[i].exp, tbl[i].name);

        // Mid-frame magnitude change is invisible until frame_start.
        set_mag(0, 400);
        drive(0, 0, 1, 0, 200, 1, 8'h00, "midframe_hold");
        drive(0, 0, 1, 0, 380, 1, PAL[0], "midframe_old_h");
        // Pixel coincident with frame_start still uses the old height.
        drive(0, 1, 1, 0, 200, 1, 8'h00, "fs_coincident");
        drive(0, 0, 1, 0, 200, 1, PAL[0], "fs_next_cycle");
        drive(0, 0, 1, 0, 79, 1, 8'h00, "h400_above");
        drive(0, 0, 1, 0, 80, 1, PAL[0], "h400_top");

        // Reset mid-frame: in-flight lit pixel blanked, bars absent until frame_start.
        drive(0, 0, 1, 96, 0, 1, 8'h00, "rst_inflight");
        drive(1, 0, 1, 96, 0, 1, 8'h00, "rst_during");
        drive(0, 0, 1, 96, 0, 1, 8'h00, "post_rst_b3");
        drive(0, 0, 1, 0, 479, 1, 8'h00, "post_rst_b0");
        drive(0, 1, 0, 0, 0, 0, 8'h00, "fs");
        drive(0, 0, 1, 96, 0, 1, PAL[3], "refill_b3");
        drive(0, 0, 1, 0, 80, 1, PAL[0], "refill_b0");
`endif

        drive(0, 0, 0, 0, 0, 0, 8'h00, "flush");
        drive(0, 0, 0, 0, 0, 0, 8'h00, "flush");
        #5;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
